// File: rtl/ws2812_tx_pkg.sv
// Shared types and default timing for the WS2812B serial encoder.
// Timing defaults assume the 12 MHz icestick board clock.
package ws2812_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BIT   = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam int TBIT_CYC_DEF   = 15;
  localparam int T0H_CYC_DEF    = 4;
  localparam int T1H_CYC_DEF    = 8;
  localparam int TRESET_CYC_DEF = 720;

  // GRB pixel layout, green sent first
  localparam int PIX_W   = 24;
  localparam int COLOR_W = 8;
  localparam int G_LSB   = 16;
  localparam int R_LSB   = 8;
  localparam int B_LSB   = 0;

  // Width of a counter that runs 0..max_count-1, never narrower than one bit
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Per-bit cycle counter: produces the registered line level for the upcoming
// cycle and a strobe marking the final cycle of the current bit period.
module ws2812_bit_timer
  import ws2812_tx_pkg::*;
#(
  parameter int TBIT_CYC = TBIT_CYC_DEF,
  parameter int T0H_CYC  = T0H_CYC_DEF,
  parameter int T1H_CYC  = T1H_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic next_active,
  input  logic next_bit,
  output logic bit_end,
  output logic dout
);

  localparam int CNT_W = cnt_width(TBIT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TBIT_CYC - 1);
  localparam logic [CNT_W-1:0] T0H_V    = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] T1H_V    = CNT_W'(T1H_CYC);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             dout_reg;

  assign bit_end = active && (cnt_reg == CNT_LAST);

  // The counter idles at zero, so a new pixel always begins at cnt 0
  always_comb begin
    cnt_next = '0;
    if (active && !bit_end) cnt_next = cnt_reg + 1'b1;
  end

  // The level is decided from the next-cycle count and bit so the pin stays registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      dout_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      dout_reg <= next_active && (cnt_next < (next_bit ? T1H_V : T0H_V));
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/ws2812_tx.sv
// WS2812B line encoder: takes GRB pixels over valid/ready, sends them MSB first
// as NRZ pulses and holds the line low for the latch period after a last pixel.
module ws2812_tx
  import ws2812_tx_pkg::*;
#(
  parameter int TBIT_CYC   = TBIT_CYC_DEF,
  parameter int T0H_CYC    = T0H_CYC_DEF,
  parameter int T1H_CYC    = T1H_CYC_DEF,
  parameter int TRESET_CYC = TRESET_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  input  logic             pix_last,
  output logic             pix_ready,
  output logic             dout,
  output logic             busy,
  output logic             underrun
);

  localparam int LAT_W = cnt_width(TRESET_CYC);
  localparam int IDX_W = cnt_width(PIX_W);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TRESET_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(PIX_W - 1);

  if (!(T0H_CYC >= 1 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC && TRESET_CYC >= 1)) begin : g_bad_timing
    $error("ws2812_tx: timing parameters must satisfy 1 <= T0H < T1H < TBIT and TRESET >= 1");
  end

  state_t           state_reg;
  logic [PIX_W-1:0] shift_reg;
  logic             last_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [LAT_W-1:0] lat_reg;
  logic             underrun_reg;

  logic bit_end;
  logic pixel_done;
  logic ready_next;
  logic xfer;
  logic next_active;
  logic next_bit;

  // Ready depends only on registered state; the current bit lives in shift_reg MSB
  always_comb begin
    pixel_done  = bit_end && (idx_reg == '0);
    ready_next  = (state_reg == ST_IDLE) || (pixel_done && !last_reg);
    xfer        = pix_valid && ready_next;
    next_active = xfer || ((state_reg == ST_BIT) && !pixel_done);
    if (xfer)         next_bit = pix_data[PIX_W-1];
    else if (bit_end) next_bit = shift_reg[PIX_W-2];
    else              next_bit = shift_reg[PIX_W-1];
  end

  ws2812_bit_timer #(
    .TBIT_CYC (TBIT_CYC),
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC)
  ) u_bit_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .active      (state_reg == ST_BIT),
    .next_active (next_active),
    .next_bit    (next_bit),
    .bit_end     (bit_end),
    .dout        (dout)
  );

  // Reset lands in LATCH so every power-up or mid-frame reset issues a full latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_LATCH;
      shift_reg    <= '0;
      last_reg     <= 1'b0;
      idx_reg      <= '0;
      lat_reg      <= '0;
      underrun_reg <= 1'b0;
    end else begin
      underrun_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (xfer) begin
            state_reg <= ST_BIT;
            shift_reg <= pix_data;
            last_reg  <= pix_last;
            idx_reg   <= IDX_MSB;
          end
        end
        ST_BIT: begin
          if (bit_end) begin
            if (idx_reg == '0) begin
              if (last_reg) begin
                state_reg <= ST_LATCH;
                lat_reg   <= '0;
              end else if (xfer) begin
                shift_reg <= pix_data;
                last_reg  <= pix_last;
                idx_reg   <= IDX_MSB;
              end else begin
                state_reg    <= ST_IDLE;
                underrun_reg <= 1'b1;
              end
            end else begin
              idx_reg   <= idx_reg - 1'b1;
              shift_reg <= {shift_reg[PIX_W-2:0], 1'b0};
            end
          end
        end
        ST_LATCH: begin
          if (lat_reg == LAT_LAST) begin
            state_reg <= ST_IDLE;
            lat_reg   <= '0;
          end else begin
            lat_reg <= lat_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign pix_ready = ready_next;
  assign busy      = (state_reg != ST_IDLE);
  assign underrun  = underrun_reg;

endmodule
